mod_add_arbiter: RTL and testbench
==================================

// Module: mod_add_arbiter
// PURPOSE
// - Shares one combinational mod_add unit (256-bit add mod secp256k1 p) between NUM_REQ requesters.
// - Round-robin arbitration, valid/ready handshake on each request port, single tagged response port.
// - Operands are registered before the adder and the sum is registered after it, which breaks the 256-bit carry path.
// - Sits between the point-add/point-double sequencers and the field-arithmetic datapath.
// PARAMETERS
// - NUM_REQ  4    number of requesters (2..8)
// - WIDTH    256  operand/result width; must equal the field width in the package
// - ID_W     2    response tag width; must be >= clog2(NUM_REQ)
// PORTS
// - clk        in   1              rising-edge clock
// - reset      in   1              synchronous, active-low; sampled on clk
// - req_valid  in   NUM_REQ        per-requester operand valid
// - req_ready  out  NUM_REQ        per-requester accept; one-hot or zero
// - req_x      in   NUM_REQ*WIDTH  operand x; requester i occupies [i*WIDTH +: WIDTH]
// - req_y      in   NUM_REQ*WIDTH  operand y; same packing as req_x
// - rsp_valid  out  1              result valid
// - rsp_ready  in   1              result consumer ready
// - rsp_sum    out  WIDTH          (x+y) mod p
// - rsp_id     out  ID_W           index of the requester that owns rsp_sum
// - busy       out  1              high whenever state != IDLE
// - op_count   out  32             completed operations; saturates at 0xFFFF_FFFF
// BEHAVIOUR
// - Reset (reset==0 at a clk edge):
//   - state=IDLE; rr_ptr=NUM_REQ-1, so the first grant goes to req 0.
//   - rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0, busy=0.
//   - Any in-flight operation is discarded; no response is ever produced for it.
// - FSM IDLE -> CALC -> DONE -> IDLE:
//   - IDLE: if any req_valid, grant g = first set bit searching from rr_ptr+1 upward, wrapping at NUM_REQ.
//     - req_ready[g]=1 combinationally in this cycle; all other bits are 0.
//     - On the edge: latch x_r, y_r and id_r=g; rr_ptr<=g; state<=CALC.
//     - No req_valid: stay in IDLE.
//   - CALC: mod_add(x_r,y_r) -> rsp_sum register; rsp_id<=id_r; rsp_valid<=1; state<=DONE.
//   - DONE: hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready==1.
//     - On that edge: rsp_valid<=0; op_count++ (saturating); state<=IDLE.
// - req_ready is 0 in CALC and DONE. Requests are accepted only in IDLE.
// - Latency: accept at edge T -> rsp_valid high after edge T+1. Minimum period is 3 cycles per op.
// - Requesters hold req_valid and operands until accepted. Deasserting before accept is legal and has no effect.
// - Operands must be < p. Behaviour for operands >= p is the mod_add contract, not checked here.
// - Simultaneous requests: strictly one grant per IDLE cycle. No starvation; worst-case wait is NUM_REQ ops.
// - Response tags follow grant order; only one op is in flight at a time.
// STRUCTURE
// - Shared package secp256k1_pkg holds:
//   - FIELD_W = 256.
//   - Constant P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F.
//   - State encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
// - One sub-module: the existing mod_add (ports x, y, sum), instantiated once on x_r/y_r.
// - Round-robin grant logic stays inline; no separate arbiter module.
// TESTING
// - Single op, no backpressure: req0 x=1, y=2, rsp_ready=1 -> rsp_sum=3, rsp_id=0, rsp_valid 2 edges after accept.
// - Wrap-around: x=P-1, y=2 -> rsp_sum=1.
//   - x=P-1, y=P-1 -> P-2.
//   - x=0, y=0 -> 0.
// - Fairness: req0..3 all valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0.
//   - Then only req0 and req2 valid after a grant to 3 -> sequence 0,2,0.
// - Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable; req_ready==0.
//   - op_count increments only on the release edge.
// - Reset mid-op: reset=0 for one edge during CALC -> rsp_valid=0, op_count=0, no response for that op.
//   - Next simultaneous req1/req2 is granted to req1 (pointer back at NUM_REQ-1).
// - Withdrawn request: req3 valid for one cycle during another op's CALC, then dropped -> never granted, no rsp_id=3.

Source files
------------

// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants and the sequencing state type for the
// shared modular-add front end.
package secp256k1_pkg;

    // Field element width.
    localparam int FIELD_W = 256;

    // Field prime p = 2^256 - 2^32 - 977.
    localparam logic [FIELD_W-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    // Arbiter sequencing: accept -> compute -> present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational (x + y) mod p for operands already reduced below p.
// The sum of two reduced operands is below 2p, so one conditional
// subtraction of p is enough to bring it back into range.
module mod_add
    import secp256k1_pkg::*;
(
    input  logic [FIELD_W-1:0] x,
    input  logic [FIELD_W-1:0] y,
    output logic [FIELD_W-1:0] sum
);

    logic [FIELD_W:0] raw;
    logic             ge_p;

    // Full-width add with carry, then fold back once if at or above p.
    always_comb begin
        raw  = {1'b0, x} + {1'b0, y};
        ge_p = (raw >= {1'b0, P});
        sum  = ge_p ? FIELD_W'(raw - {1'b0, P}) : raw[FIELD_W-1:0];
    end

endmodule

// File: rtl/mod_add_arbiter.sv
// Round-robin front end that time-shares a single mod_add between NUM_REQ
// requesters. One operation is in flight at a time; operands are captured
// into registers ahead of the adder and the result is registered behind it,
// so the long carry chain sits alone between two flop stages.
module mod_add_arbiter
    import secp256k1_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = FIELD_W,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [31:0]              op_count
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Requester i's operands live at [i*WIDTH +: WIDTH]; a packed 2-D view
    // gives the same bit layout with plain indexing.
    logic [NUM_REQ-1:0][WIDTH-1:0] x_arr;
    logic [NUM_REQ-1:0][WIDTH-1:0] y_arr;

    assign x_arr = req_x;
    assign y_arr = req_y;

    state_e             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic [ID_W-1:0]    id_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rsp_sum_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [31:0]        op_count_q;

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     cand;
    logic [WIDTH-1:0]   sum_w;

    // Round-robin search: first valid requester strictly after the last
    // winner, wrapping at NUM_REQ. The extra bit on cand holds ptr+i before
    // the wrap so NUM_REQ need not be a power of two.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    // Ready is offered only while idle, and only to the round-robin winner.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The shared adder always sees the captured operands.
    mod_add u_mod_add (
        .x   (x_q),
        .y   (y_q),
        .sum (sum_w)
    );

    // Accept / compute / present sequencer. A reset drops any in-flight
    // operation without ever presenting its result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        x_q      <= x_arr[grant_idx];
                        y_q      <= y_arr[grant_idx];
                        id_q     <= ID_W'(grant_idx);
                        rr_ptr_q <= grant_idx;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= sum_w;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // Result stays put until the consumer takes it.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (op_count_q != 32'hFFFF_FFFF) begin
                            op_count_q <= op_count_q + 32'd1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Directed bench for mod_add_arbiter with a transaction-level reference
// model checked every cycle, plus hand-computed expectations.
module tb_mod_add_arbiter;
    import secp256k1_pkg::*;

    localparam int N = 4;
    localparam logic [255:0] PM1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
    localparam logic [255:0] PM2 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      vld;
    logic [N-1:0]      req_ready;
    logic [N-1:0][255:0] tx;
    logic [N-1:0][255:0] ty;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [255:0]      rsp_sum;
    logic [1:0]        rsp_id;
    logic              busy;
    logic [31:0]       op_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_add_arbiter #(.NUM_REQ(N), .WIDTH(256), .ID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (vld),
        .req_ready (req_ready),
        .req_x     (tx),
        .req_y     (ty),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [255:0] modsum(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = {256'b0, a} + {256'b0, b};
        t = t % {256'b0, P};
        return t[255:0];
    endfunction

    function automatic int pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    bit           m_on = 0;     // model initialised by a reset edge
    bit           m_infl;       // an operation has been accepted and not yet retired
    bit           m_rv;         // result is being presented
    int           m_last;       // last requester granted
    logic [255:0] m_psum, m_sum;
    int           m_pid, m_id;
    longint       m_cnt;

    always @(posedge clk) begin
        if (!reset) begin
            m_on = 1; m_infl = 0; m_rv = 0; m_last = N - 1;
            m_sum = '0; m_id = 0; m_cnt = 0;
        end else if (m_on) begin
            if (!m_infl) begin
                int g;
                g = pick(m_last, vld);
                if (g >= 0) begin
                    m_infl = 1; m_last = g;
                    m_psum = modsum(tx[g], ty[g]); m_pid = g;
                end
            end else if (!m_rv) begin
                m_rv = 1; m_sum = m_psum; m_id = m_pid;
            end else if (rsp_ready) begin
                m_rv = 0; m_infl = 0;
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            end
        end
    end

    // Expected ready: the round-robin winner, only when nothing is in flight.
    always @(negedge clk) begin
        if (m_on) begin
            logic [N-1:0] er;
            int g;
            er = '0;
            g = pick(m_last, vld);
            if (!m_infl && g >= 0) er[g] = 1'b1;
            chk("cyc_req_ready", req_ready, er);
            chk("cyc_rsp_valid", rsp_valid, m_rv);
            chk("cyc_rsp_sum", rsp_sum, m_sum);
            chk("cyc_rsp_id", rsp_id, m_id);
            chk("cyc_busy", busy, m_infl);
            chk("cyc_op_count", op_count, m_cnt);
        end
    end

    // Log of retired responses as seen on the DUT port.
    int           log_id[$];
    logic [255:0] log_sum[$];
    always @(posedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            log_id.push_back(int'(rsp_id));
            log_sum.push_back(rsp_sum);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise a request and hold it until accepted; returns just after the accept edge.
    task automatic op(input int i, input logic [255:0] a, input logic [255:0] b);
        bit acc;
        acc = 0;
        tx[i] = a; ty[i] = b; vld[i] = 1'b1;
        for (int c = 0; c < 60 && !acc; c++) begin
            #1;
            acc = req_ready[i];
            @(posedge clk);
            #1;
        end
        vld[i] = 1'b0;
        if (!acc) chk("op_accept_timeout", 0, 1);
    endtask

    task automatic wait_log(input int n);
        for (int c = 0; c < 200 && log_id.size() < n; c++) tick(1);
        chk("wait_rsp_count", log_id.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, cnt3;
        int exp_ids[7];
        reset = 1'b0; vld = '0; rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin tx[i] = '0; ty[i] = '0; end
        tick(2);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        reset = 1'b1;
        tick(1);

        // Single op with latency checks: 1 + 2 on requester 0.
        tx[0] = 256'd1; ty[0] = 256'd2; vld = 4'b0001;
        #1;
        chk("t1_ready_req0", req_ready, 4'b0001);
        @(posedge clk); #1;                  // accept edge
        vld = '0;
        chk("t1_calc_no_valid", rsp_valid, 0);
        chk("t1_calc_busy", busy, 1);
        tick(1);                             // result edge
        chk("t1_valid", rsp_valid, 1);
        chk("t1_sum", rsp_sum, 256'd3);
        chk("t1_id", rsp_id, 0);
        chk("t1_count_before", op_count, 0);
        tick(1);                             // release edge
        chk("t1_valid_drop", rsp_valid, 0);
        chk("t1_count_after", op_count, 1);

        // Reduction boundaries.
        op(1, PM1, 256'd2);
        op(2, PM1, PM1);
        op(3, 256'd0, 256'd0);
        wait_log(4);
        chk("wrap_sum_pm1_2", log_sum[1], 256'd1);
        chk("wrap_id1", log_id[1], 1);
        chk("wrap_sum_pm1_pm1", log_sum[2], PM2);
        chk("wrap_id2", log_id[2], 2);
        chk("wrap_sum_zero", log_sum[3], 256'd0);
        chk("wrap_id3", log_id[3], 3);
        tick(2);

        // Fairness: everyone valid, then only 0 and 2.
        log_id.delete(); log_sum.delete();
        for (int i = 0; i < N; i++) begin tx[i] = 256'(i); ty[i] = 256'd10; end
        vld = 4'b1111;
        wait_log(4);
        vld = 4'b0101;
        wait_log(7);
        vld = '0;
        exp_ids = '{0, 1, 2, 3, 0, 2, 0};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("fair_id_%0d", k), log_id[k], exp_ids[k]);
            chk($sformatf("fair_sum_%0d", k), log_sum[k], 256'(exp_ids[k] + 10));
        end
        tick(3);
        chk("fair_count", op_count, 11);

        // Backpressure: result held for 5 cycles while req0 waits.
        rsp_ready = 1'b0;
        op(1, 256'd5, 256'd6);
        for (int c = 0; c < 10 && !rsp_valid; c++) tick(1);
        tx[0] = 256'd9; ty[0] = 256'd9; vld[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_sum", rsp_sum, 256'd11);
            chk("bp_id", rsp_id, 1);
            chk("bp_no_ready", req_ready, 0);
            chk("bp_count_held", op_count, 11);
            tick(1);
        end
        vld[0] = 1'b0;
        rsp_ready = 1'b1;
        tick(1);
        chk("bp_release_count", op_count, 12);
        chk("bp_release_valid", rsp_valid, 0);
        tick(2);

        // Reset during CALC discards the op and rewinds the pointer.
        op(0, 256'd7, 256'd8);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_count", op_count, 0);
        chk("rst_mid_busy", busy, 0);
        base = log_id.size();
        tick(5);
        chk("rst_mid_no_rsp", log_id.size(), base);
        tx[1] = 256'd20; ty[1] = 256'd22; tx[2] = 256'd30; ty[2] = 256'd31;
        vld = 4'b0110;
        #1;
        chk("rst_grant_req1", req_ready, 4'b0010);
        tick(1);
        vld = '0;
        wait_log(base + 1);
        chk("rst_rsp_id", log_id[base], 1);
        chk("rst_rsp_sum", log_sum[base], 256'd42);
        tick(2);

        // Withdrawn request during another op's CALC is never served.
        base = log_id.size();
        op(0, 256'd3, 256'd4);
        tx[3] = 256'd100; ty[3] = 256'd1; vld[3] = 1'b1;
        tick(1);
        vld[3] = 1'b0;
        wait_log(base + 1);
        tick(6);
        chk("wd_rsp_count", log_id.size(), base + 1);
        chk("wd_id", log_id[base], 0);
        chk("wd_sum", log_sum[base], 256'd7);
        cnt3 = 0;
        for (int k = base; k < log_id.size(); k++) if (log_id[k] == 3) cnt3++;
        chk("wd_no_id3", cnt3, 0);
        chk("wd_count", op_count, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
